avalon_mem_port: RTL and testbench
==================================

# avalon_mem_port

- Bus-master adapter between the CPU core's memory-request side (fetch and load/store) and the Avalon memory-mapped bus.
- Accepts one word-aligned read or write request at a time and holds the Avalon signals stable while `waitrequest` is asserted.
- Captures read data and returns it with a single-cycle response pulse.
- Raises `stall` so the core's FETCH/EXEC1/EXEC2 sequencer freezes until the access completes; counts wait cycles for performance debug.

## Interface

- `TIMEOUT_CYCLES`, 1024: maximum consecutive `waitrequest` cycles before the access is abandoned.
- `CNT_W`, 32: width of the wait-cycle counter.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: core presents a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address; bits [1:0] are ignored.
- `req_byteenable` in 4: lane enables; bit 3 = bits [31:24] (big-endian lane order, matching load/store).
- `req_writedata` in 32: write data, already lane-positioned.
- `req_ready` out 1: request accepted this cycle.
- `rsp_valid` out 1: one-cycle pulse; access complete.
- `rsp_readdata` out 32: captured read data; valid with `rsp_valid` on reads and held until the next read response.
- `rsp_err` out 1: with `rsp_valid`; 1 = timeout.
- `stall` out 1: core must not advance state.
- `wait_count` out CNT_W: total `waitrequest`-stalled cycles since reset; saturating.
- `address` out 32: Avalon address, always `{req_addr[31:2],2'b00}`.
- `read`, `write` out 1 each: Avalon strobes.
- `byteenable` out 4: Avalon lane enables.
- `writedata` out 32: Avalon write data.
- `waitrequest` in 1: slave not ready.
- `readdata` in 32: slave read data.

## Operation

- States:
  - IDLE
  - REQ: strobe asserted, waiting for acceptance.
  - RDATA: read accepted, data arrives.
  - RESP: response pulse.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` with non-zero byteenable: latch addr, be, wdata, write into holding registers, then go to REQ.
  - On `req_valid` with `req_byteenable`=0: no bus access; go to RESP with `rsp_err`=0 and `rsp_readdata` unchanged.
- REQ:
  - Drive `read` or `write` from the latched request; Avalon outputs are sourced only from holding registers, so they stay stable while `waitrequest`=1.
  - `waitrequest`=0 on a write: go to RESP.
  - `waitrequest`=0 on a read: go to RDATA.
  - `waitrequest`=1: increment the timeout counter and `wait_count`.
  - Timeout counter reaching `TIMEOUT_CYCLES`: deassert strobes, go to RESP with `rsp_err`=1.
- RDATA: strobes low; capture `readdata` into `rsp_readdata`; go to RESP.
- RESP: `rsp_valid`=1 for exactly one cycle; return to IDLE.
- `stall` = `req_valid` & ~`req_ready`, or state ≠ IDLE.
- `req_valid` in a non-IDLE state is ignored (not queued); the core must hold it.
- `read` and `write` are never both 1.
- `wait_count` saturates at all-ones; it does not wrap.

## Timing

- Reset (`rst_n`=0 at an edge) applies these values:
  - state IDLE; `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_readdata`=0.
  - `read`=0, `write`=0, `byteenable`=0, `writedata`=0, `address`=0.
  - `wait_count`=0, timeout counter=0, `stall`=0.
- Reset mid-access: strobes drop in the cycle after the reset edge; no response pulse is issued.
- Latency, zero-wait write: request accepted cycle N, strobe cycles N+1, `rsp_valid` cycle N+2.
- Latency, zero-wait read: strobe cycle N+1, data captured N+2, `rsp_valid` N+3 with data.
- Each `waitrequest` cycle adds one cycle to latency.
- Timeout: the strobe is high for exactly `TIMEOUT_CYCLES` cycles; `rsp_valid`+`rsp_err` follow in the next cycle.
- Back-to-back: a new request may be accepted in the cycle after RESP, giving a minimum of 3 cycles per write.

## Structure

- Shared package `mips_cpu_pkg` holds:
  - State enum `mem_port_state_t` (IDLE, REQ, RDATA, RESP).
  - Constant `WORD_ALIGN_MASK` = 32'hFFFF_FFFC.
  - Default `TIMEOUT_CYCLES`.
- Single sub-module `sat_counter` (parameterised width, increment enable, synchronous clear) is used for both `wait_count` and the timeout counter.

## Test plan

- Zero-wait write: `req_addr`=0x1003, be=4'b0001, wdata=0xAB → `address`=0x1000, `write` high 1 cycle, `rsp_valid` 2 cycles after acceptance, `rsp_err`=0.
- Read with 3 wait cycles: `readdata`=0xDEADBEEF → `read` high 4 cycles with stable address/be, `rsp_readdata`=0xDEADBEEF, `wait_count`=3.
- Timeout with `TIMEOUT_CYCLES`=8 and `waitrequest` stuck high → strobe high 8 cycles, then `rsp_valid`=1 with `rsp_err`=1, state returns to IDLE.
- `req_byteenable`=0 → no `read`/`write` pulse, `rsp_valid` one cycle later, `rsp_readdata` unchanged.
- `rst_n` low during REQ with `waitrequest` high → outputs at reset values next cycle; no `rsp_valid`; the next request completes normally.
- New `req_valid` held while busy → ignored; accepted only in IDLE after RESP; `stall` high throughout.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pkg
// Purpose  : Shared types and constants for the CPU core's memory-port logic.
//            Defines the bus-master state enum, the word-alignment mask and
//            the default waitrequest timeout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // ready for a new request
        ST_REQ   = 2'd1,   // strobe asserted, waiting for the slave
        ST_RDATA = 2'd2,   // read accepted, data arrives this cycle
        ST_RESP  = 2'd3    // one-cycle response pulse
    } mem_port_state_t;

    localparam logic [31:0] WORD_ALIGN_MASK        = 32'hFFFF_FFFC;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
//            Synchronous clear has priority over increment.
// Ports    : clk    - clock, rising edge
//            rst_n  - synchronous active-low reset (count -> 0)
//            clr    - synchronous clear
//            inc    - increment enable
//            count  - current count value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/avalon_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : avalon_mem_port
// Purpose  : Bus-master adapter from the core's fetch/load-store request port
//            to an Avalon-MM master. One word-aligned access at a time, Avalon
//            outputs held stable under waitrequest, read data captured and
//            returned with a one-cycle response pulse, stall to freeze the
//            core sequencer, saturating wait-cycle counter, and a timeout that
//            abandons an access stuck on waitrequest.
// Ports    : clk, rst_n                     - clock / sync active-low reset
//            req_valid/req_write/req_addr/
//            req_byteenable/req_writedata   - core request
//            req_ready                      - request accepted this cycle
//            rsp_valid/rsp_readdata/rsp_err - core response
//            stall                          - core must hold state
//            wait_count                     - total waitrequest cycles
//            address/read/write/byteenable/
//            writedata/waitrequest/readdata - Avalon-MM master side
// Revision : 1.0 - initial release
// ============================================================================
module avalon_mem_port
    import mips_cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    // core request side
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [3:0]       req_byteenable,
    input  logic [31:0]      req_writedata,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [31:0]      rsp_readdata,
    output logic             rsp_err,
    output logic             stall,
    output logic [CNT_W-1:0] wait_count,
    // Avalon-MM master side
    output logic [31:0]      address,
    output logic             read,
    output logic             write,
    output logic [3:0]       byteenable,
    output logic [31:0]      writedata,
    input  logic             waitrequest,
    input  logic [31:0]      readdata
);

    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Last permitted waitrequest cycle: the strobe has then been high for
    // exactly TIMEOUT_CYCLES cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    mem_port_state_t state_q, state_d;
    logic [31:0]     addr_q,  addr_d;
    logic [3:0]      be_q,    be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            write_q, write_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q,   err_d;

    logic            wait_cycle;
    logic [TO_W-1:0] to_count;

    assign wait_cycle = (state_q == ST_REQ) && waitrequest;

    // Timeout counter only runs inside REQ, so leaving REQ re-arms it.
    sat_counter #(
        .WIDTH (TO_W)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != ST_REQ),
        .inc   (wait_cycle),
        .count (to_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (wait_cycle),
        .count (wait_count)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    err_d = 1'b0;
                    if (req_byteenable != 4'b0000) begin
                        addr_d  = req_addr & WORD_ALIGN_MASK;
                        be_d    = req_byteenable;
                        wdata_d = req_writedata;
                        write_d = req_write;
                        state_d = ST_REQ;
                    end else begin
                        // Nothing to transfer: acknowledge without a bus cycle.
                        state_d = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (!waitrequest) begin
                    state_d = write_q ? ST_RESP : ST_RDATA;
                end else if (to_count == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RDATA: begin
                rdata_d = readdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Avalon outputs come only from the holding registers, so they cannot
    // move while the slave asserts waitrequest.
    assign address      = addr_q;
    assign byteenable   = be_q;
    assign writedata    = wdata_q;
    assign read         = (state_q == ST_REQ) && !write_q;
    assign write        = (state_q == ST_REQ) &&  write_q;

    assign req_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_err      = rsp_valid && err_q;
    assign rsp_readdata = rdata_q;
    assign stall        = (req_valid && !req_ready) || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_mem_port
// Purpose  : Self-checking bench for avalon_mem_port. The driver issues
//            directed accesses and pushes the expected response (error flag,
//            read data, arrival cycle) into a scoreboard queue; a monitor pops
//            and compares whenever rsp_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_mem_port;

    localparam int T  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_write;
    logic [31:0]   req_addr;
    logic [3:0]    req_byteenable;
    logic [31:0]   req_writedata;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_readdata;
    logic          rsp_err;
    logic          stall;
    logic [CW-1:0] wait_count;
    logic [31:0]   address;
    logic          read;
    logic          write;
    logic [3:0]    byteenable;
    logic [31:0]   writedata;
    logic          waitrequest;
    logic [31:0]   readdata;

    avalon_mem_port #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_byteenable (req_byteenable),
        .req_writedata  (req_writedata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_readdata   (rsp_readdata),
        .rsp_err        (rsp_err),
        .stall          (stall),
        .wait_count     (wait_count),
        .address        (address),
        .read           (read),
        .write          (write),
        .byteenable     (byteenable),
        .writedata      (writedata),
        .waitrequest    (waitrequest),
        .readdata       (readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hold_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Response monitor / scoreboard checker.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, none required", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_err",      {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_readdata", rsp_readdata,     e.rdata);
                chk("rsp_cycle",    cyc,              e.cyc);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, ":req_ready"},    {31'd0, req_ready},  32'd1);
        chk({tag, ":rsp_valid"},    {31'd0, rsp_valid},  32'd0);
        chk({tag, ":rsp_err"},      {31'd0, rsp_err},    32'd0);
        chk({tag, ":rsp_readdata"}, rsp_readdata,        32'd0);
        chk({tag, ":read"},         {31'd0, read},       32'd0);
        chk({tag, ":write"},        {31'd0, write},      32'd0);
        chk({tag, ":byteenable"},   {28'd0, byteenable}, 32'd0);
        chk({tag, ":writedata"},    writedata,           32'd0);
        chk({tag, ":address"},      address,             32'd0);
        chk({tag, ":wait_count"},   {28'd0, wait_count}, 32'd0);
        chk({tag, ":stall"},        {31'd0, stall},      32'd0);
    endtask

    // Called at a falling edge while the DUT is idle; returns at a falling
    // edge with the DUT idle again. keep=1 models a core that keeps
    // req_valid asserted while the port is busy.
    task automatic do_access(input string nm, input bit wr, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd, input int nwait,
                             input logic [31:0] rd, input bit tmo, input bit keep);
        int   c0;
        int   ns;
        bit   ok;
        exp_t e;
        chk({nm, ":ready"},      {31'd0, req_ready},     32'd1);
        chk({nm, ":idle_strobe"}, {31'd0, read | write}, 32'd0);
        req_valid      = 1'b1;
        req_write      = wr;
        req_addr       = addr;
        req_byteenable = be;
        req_writedata  = wd;
        c0 = cyc;
        e.err = tmo;
        if (be == 4'b0000)  e.cyc = c0 + 1;
        else if (tmo)       e.cyc = c0 + 1 + T;
        else if (wr)        e.cyc = c0 + 2 + nwait;
        else                e.cyc = c0 + 3 + nwait;
        if (be != 4'b0000 && !wr && !tmo) hold_rd = rd;
        e.rdata = hold_rd;
        sb.push_back(e);

        ns = (be == 4'b0000) ? 0 : (tmo ? T : nwait + 1);
        for (int i = 0; i < ns; i++) begin
            @(negedge clk);
            if (!keep) req_valid = 1'b0;
            waitrequest = tmo || (i < nwait);
            readdata    = 32'h5A5A_5A5A;
            chk({nm, ":read"},    {31'd0, read},       {31'd0, !wr});
            chk({nm, ":write"},   {31'd0, write},      {31'd0, wr});
            chk({nm, ":address"}, address,             addr & 32'hFFFF_FFFC);
            chk({nm, ":be"},      {28'd0, byteenable}, {28'd0, be});
            if (wr) chk({nm, ":wdata"}, writedata, wd);
            chk({nm, ":stall"},   {31'd0, stall},      32'd1);
            if (keep) chk({nm, ":busy_ready"}, {31'd0, req_ready}, 32'd0);
        end

        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        waitrequest = 1'b0;
        readdata    = rd;
        chk({nm, ":strobe_off"}, {31'd0, read | write}, 32'd0);

        ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            chk({nm, ":busy_stall"}, {31'd0, stall}, 32'd1);
            @(negedge clk);
            readdata = 32'h5A5A_5A5A;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s:return_idle: req_ready=%0b after 12 cycles, required 1", nm, req_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_addr       = '0;
        req_byteenable = '0;
        req_writedata  = '0;
        waitrequest    = 1'b0;
        readdata       = '0;
        hold_rd        = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // zero-wait write, unaligned address
        do_access("zw_write", 1'b1, 32'h0000_1003, 4'b0001, 32'h0000_00AB, 0, 32'h0, 1'b0, 1'b0);
        chk("zw_write:wait_count", {28'd0, wait_count}, 32'd0);

        // read with three wait cycles
        do_access("rd_wait3", 1'b0, 32'h0000_4010, 4'b1111, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("rd_wait3:wait_count", {28'd0, wait_count}, 32'd3);

        // no lanes enabled: no bus cycle, read data held
        do_access("be_zero", 1'b0, 32'h0000_0050, 4'b0000, 32'h0, 0, 32'h1111_2222, 1'b0, 1'b0);
        chk("be_zero:wait_count", {28'd0, wait_count}, 32'd3);

        // read timeout: waitrequest stuck high
        do_access("tmo_read", 1'b0, 32'h0000_6000, 4'b1111, 32'h0, 0, 32'h3333_4444, 1'b1, 1'b0);
        chk("tmo_read:wait_count", {28'd0, wait_count}, 32'd11);

        // write timeout pushes wait_count past all-ones: must saturate
        do_access("tmo_write", 1'b1, 32'h0000_7001, 4'b1000, 32'h1100_0000, 0, 32'h0, 1'b1, 1'b0);
        chk("tmo_write:wait_count_sat", {28'd0, wait_count}, 32'd15);

        // reset in the middle of a stalled read
        req_valid      = 1'b1;
        req_write      = 1'b0;
        req_addr       = 32'h0000_2000;
        req_byteenable = 4'b1111;
        waitrequest    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid:read_before", {31'd0, read}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        rst_n       = 1'b1;
        waitrequest = 1'b0;
        hold_rd     = '0;

        do_access("post_reset", 1'b1, 32'h0000_2004, 4'b1100, 32'hCAFE_0000, 2, 32'h0, 1'b0, 1'b0);
        chk("post_reset:wait_count", {28'd0, wait_count}, 32'd2);

        // request held while busy is only re-accepted after returning to idle
        do_access("held_a", 1'b1, 32'h0000_3008, 4'b0011, 32'h0000_1234, 1, 32'h0, 1'b0, 1'b1);
        chk("held_a:wait_count", {28'd0, wait_count}, 32'd3);
        do_access("held_b", 1'b1, 32'h0000_3008, 4'b0011, 32'h0000_1234, 0, 32'h0, 1'b0, 1'b0);
        chk("held_b:wait_count", {28'd0, wait_count}, 32'd3);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
